// File: rtl/spi_frame_controller.sv
// spi_frame_controller
// --------------------------------------------------------------------------
// Frame-level SPI slave controller. It consumes pre-conditioned SPI signals
// (synchronised chip select, one-clk SCLK edge pulses, MOSI level). It turns
// each frame into one register-file access.
//
// Frame layout, MSB first, sampled on SCLK rising edges:
//   ADDR_WIDTH address bits, one R/W bit (1 = read), then DATA_WIDTH data bits.
//   Write: the data bits arrive on MOSI and are committed with one wr_en pulse.
//   Read : rd_en is pulsed once and rd_data is loaded one clk later. The data
//          is then shifted out on MISO and changes on SCLK falling edges.
//
// Ports
//   clk, reset_n      single clock; asynchronous active-low reset
//   cs_cond           conditioned chip select, active low
//   sclk_posedge      one-clk pulse per SCLK rising edge
//   sclk_negedge      one-clk pulse per SCLK falling edge
//   mosi_cond         conditioned MOSI level
//   rd_data           register-file read data, valid one clk after rd_en
//   addr, wr_data     captured address / write data
//   wr_en, rd_en      register-file strobes
//   miso, miso_oe     serial read data and its tristate enable
//   busy              high whenever the FSM is not IDLE
//   state_dbg         current FSM state. Encoding: 0 IDLE, 1 ADDR, 2 READ_REQ,
//                     3 READ_LOAD, 4 READ_TX, 5 WRITE_RX, 6 WRITE_COMMIT, 7 DONE
//
// Strobe semantics: wr_en and rd_en are single-clk pulses with no handshake.
// The register file must accept a write in the wr_en cycle, with addr and
// wr_data stable. It must return read data on the clk after rd_en.
// --------------------------------------------------------------------------
module spi_frame_controller #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cs_cond,
  input  logic                  sclk_posedge,
  input  logic                  sclk_negedge,
  input  logic                  mosi_cond,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic                  miso,
  output logic                  miso_oe,
  output logic                  busy,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_ADDR         = 3'd1,
    S_READ_REQ     = 3'd2,
    S_READ_LOAD    = 3'd3,
    S_READ_TX      = 3'd4,
    S_WRITE_RX     = 3'd5,
    S_WRITE_COMMIT = 3'd6,
    S_DONE         = 3'd7
  } state_t;

  localparam int MAX_BITS = (ADDR_WIDTH + 1 > DATA_WIDTH) ? ADDR_WIDTH + 1 : DATA_WIDTH;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  state_t                  state, state_next;
  // Only the address bits are stored. The trailing R/W bit is acted on
  // directly from mosi_cond on the final address posedge.
  logic [ADDR_WIDTH-1:0]   addr_sr;
  logic [DATA_WIDTH-1:0]   tx_sr;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    present_seen;
  logic                    cs_armed;
  logic                    pos_evt, neg_evt, addr_done, data_done;

  // A falling-edge pulse coincident with a rising-edge pulse is dropped.
  assign pos_evt   = sclk_posedge;
  assign neg_evt   = sclk_negedge & ~sclk_posedge;
  assign addr_done = pos_evt && (bit_cnt == ADDR_LAST);
  assign data_done = pos_evt && (bit_cnt == DATA_LAST);
  assign state_dbg = state;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state logic. Chip-select release wins over every other event.
  always_comb begin
    state_next = state;
    if (state != S_IDLE && cs_cond) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:         if (!cs_cond && cs_armed) state_next = S_ADDR;
        S_ADDR:         if (addr_done) state_next = mosi_cond ? S_READ_REQ : S_WRITE_RX;
        S_READ_REQ:     state_next = S_READ_LOAD;
        S_READ_LOAD:    state_next = S_READ_TX;
        S_READ_TX:      if (data_done) state_next = S_DONE;
        S_WRITE_RX:     if (data_done) state_next = S_WRITE_COMMIT;
        S_WRITE_COMMIT: state_next = S_DONE;
        S_DONE:         state_next = S_DONE;
        default:        state_next = S_IDLE;
      endcase
    end
  end

  // Output decode. Every output is derived from the state, so reset clears
  // it immediately along with the state register.
  always_comb begin
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    miso_oe = 1'b0;
    miso    = 1'b0;
    busy    = 1'b0;
    if (state == S_WRITE_COMMIT) wr_en = 1'b1;
    if (state == S_READ_REQ)     rd_en = 1'b1;
    if (state == S_READ_TX) begin
      miso_oe = 1'b1;
      miso    = tx_sr[DATA_WIDTH-1];
    end
    if (state != S_IDLE) busy = 1'b1;
  end

  // Datapath: shift registers, bit counter, present-edge flag.
  // cs_armed blocks a chip select that was already low when reset released.
  // A frame starts only after cs_cond has been seen high at least once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_sr      <= '0;
      addr         <= '0;
      wr_data      <= '0;
      tx_sr        <= '0;
      bit_cnt      <= '0;
      present_seen <= 1'b0;
      cs_armed     <= 1'b0;
    end else begin
      if (cs_cond) cs_armed <= 1'b1;
      if (!cs_cond) begin
        case (state)
          S_IDLE: begin
            addr_sr      <= '0;
            bit_cnt      <= '0;
            present_seen <= 1'b0;
          end
          S_ADDR: begin
            if (pos_evt) begin
              addr_sr <= {addr_sr[ADDR_WIDTH-2:0], mosi_cond};
              if (addr_done) begin
                addr    <= addr_sr;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          // The first falling edge after the address is the present edge.
          // The master expects the MSB to be on MISO already, so it only
          // records that the edge happened.
          S_READ_REQ: begin
            if (neg_evt) present_seen <= 1'b1;
          end
          S_READ_LOAD: begin
            tx_sr   <= rd_data;
            bit_cnt <= '0;
            if (neg_evt) present_seen <= 1'b1;
          end
          S_READ_TX: begin
            if (pos_evt) begin
              bit_cnt <= bit_cnt + 1'b1;
            end else if (neg_evt) begin
              if (present_seen) tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
              else              present_seen <= 1'b1;
            end
          end
          S_WRITE_RX: begin
            if (pos_evt) begin
              wr_data <= {wr_data[DATA_WIDTH-2:0], mosi_cond};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_controller.sv
// Testbench for spi_frame_controller: random SPI frames against a
// transaction-level model (write -> {addr,data} commit, read -> register
// contents appearing serially on MISO), plus directed edge cases.
module tb_spi_frame_controller;

  localparam int AW = 7;
  localparam int DW = 8;
  localparam int TW = 1 + AW + DW;   // {is_write, addr, data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic          cs_cond, sclk_posedge, sclk_negedge, mosi_cond;
  logic [DW-1:0] rd_data = '0;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic          wr_en, rd_en, miso, miso_oe, busy;
  logic [2:0]    state_dbg;

  spi_frame_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cs_cond      (cs_cond),
    .sclk_posedge (sclk_posedge),
    .sclk_negedge (sclk_negedge),
    .mosi_cond    (mosi_cond),
    .rd_data      (rd_data),
    .addr         (addr),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .miso         (miso),
    .miso_oe      (miso_oe),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  // Register file model: fixed random contents, one-clk read latency.
  logic [DW-1:0] rf [0:(1<<AW)-1];
  always @(posedge clk) if (rd_en) rd_data <= rf[addr];

  // ---------------- scoreboard ----------------
  logic [TW-1:0] exp_q[$];
  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic score(input logic [TW-1:0] act);
    logic [TW-1:0] e;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL txn_unexpected: got 0x%0h expected no transaction", act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        mismatched++;
        $display("FAIL txn: got 0x%0h expected 0x%0h", act, e);
      end
    end
  endtask

  // ---------------- monitor ----------------
  logic          rd_active = 1'b0;
  logic [AW-1:0] rd_addr   = '0;
  logic [DW-1:0] rd_bits   = '0;
  int            rd_cnt    = 0;
  logic          prev_wr   = 1'b0;
  logic          prev_rd   = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      rd_active = 1'b0;
      prev_wr   = 1'b0;
      prev_rd   = 1'b0;
    end else begin
      if (wr_en || rd_en) begin
        compared++;
        if ((wr_en && rd_en) || (wr_en && prev_wr) || (rd_en && prev_rd)) begin
          mismatched++;
          $display("FAIL strobe_rule: wr_en=%0b rd_en=%0b prev_wr=%0b prev_rd=%0b expected one exclusive single-clk pulse",
                   wr_en, rd_en, prev_wr, prev_rd);
        end
      end
      if (wr_en) score({1'b1, addr, wr_data});
      if (rd_en) begin
        rd_active = 1'b1;
        rd_addr   = addr;
        rd_bits   = '0;
        rd_cnt    = 0;
      end else if (rd_active && sclk_posedge && miso_oe) begin
        rd_bits = {rd_bits[DW-2:0], miso};
        rd_cnt++;
        if (rd_cnt == DW) begin
          score({1'b0, rd_addr, rd_bits});
          rd_active = 1'b0;
        end
      end
      if (!busy) rd_active = 1'b0;
      prev_wr = wr_en;
      prev_rd = rd_en;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One SPI bit: rising pulse, gap, falling pulse, gap.
  // both   : the falling pulse is also raised in the rising-pulse clk.
  // cs_with: chip select is released in the same clk as the rising pulse.
  task automatic sclk_bit(input logic b, input bit both, input bit cs_with);
    int g = $urandom_range(1, 3);
    mosi_cond    = b;
    sclk_posedge = 1'b1;
    sclk_negedge = both;
    if (cs_with) cs_cond = 1'b1;
    step(1);
    sclk_posedge = 1'b0;
    sclk_negedge = 1'b0;
    if (cs_with) return;
    step(g);
    sclk_negedge = 1'b1;
    step(1);
    sclk_negedge = 1'b0;
    step(g);
  endtask

  // mode 0: complete frame
  // mode 1: chip select released after 'cut' data bits
  // mode 2: chip select released together with the final data rising edge
  // mode 3: reset asserted after 'cut' data bits (read frames)
  task automatic run_frame(input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int mode, input int cut);
    logic [DW-1:0] exp_data;
    exp_data = rw ? rf[a] : d;
    if (mode == 0) exp_q.push_back({~rw, a, exp_data});
    cs_cond = 1'b0;
    step(1);
    check("busy_after_cs_low", busy, 1);
    step(1);
    for (int i = AW - 1; i >= 0; i--) sclk_bit(a[i], 1'b0, 1'b0);
    sclk_bit(rw, 1'b0, 1'b0);
    for (int i = DW - 1; i >= 0; i--) begin
      if ((mode == 1 || mode == 3) && (DW - 1 - i) == cut) break;
      sclk_bit(rw ? 1'($urandom_range(0, 1)) : d[i],
               !rw && (i == 3 || $urandom_range(0, 3) == 0),
               mode == 2 && i == 0);
    end
    case (mode)
      0: begin
        step(2);
        check("busy_in_done", busy, 1);
        sclk_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        sclk_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        check("busy_done_ignores_sclk", busy, 1);
        check("addr_held", addr, a);
        if (!rw) check("wr_data_held", wr_data, d);
        cs_cond = 1'b1;
        step(1);
        check("busy_after_cs_high", busy, 0);
        check("miso_oe_idle", miso_oe, 0);
        step(2);
      end
      1: begin
        cs_cond = 1'b1;
        step(1);
        check("busy_after_abort", busy, 0);
        step(2);
      end
      2: begin
        check("busy_after_coincident_cs", busy, 0);
        step(2);
      end
      default: begin
        check("miso_oe_in_read_tx", miso_oe, 1);
        #1 reset_n = 1'b0;
        #1;
        check("rst_wr_en", wr_en, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_miso", miso, 0);
        check("rst_miso_oe", miso_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", addr, 0);
        check("rst_wr_data", wr_data, 0);
        step(2);
        reset_n = 1'b1;
        step(4);
        check("no_frame_without_fresh_cs", busy, 0);
        cs_cond = 1'b1;
        step(2);
      end
    endcase
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < (1 << AW); i++) rf[i] = DW'($urandom);
    rf[5] = 8'h96;
    reset_n      = 1'b0;
    cs_cond      = 1'b1;
    sclk_posedge = 1'b0;
    sclk_negedge = 1'b0;
    mosi_cond    = 1'b0;
    #12;
    check("reset_addr", addr, 0);
    check("reset_wr_data", wr_data, 0);
    check("reset_wr_en", wr_en, 0);
    check("reset_rd_en", rd_en, 0);
    check("reset_miso", miso, 0);
    check("reset_miso_oe", miso_oe, 0);
    check("reset_busy", busy, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    step(3);

    run_frame(1'b0, 7'h2A, 8'hC3, 0, 0);                 // directed write
    run_frame(1'b1, 7'h05, 8'h00, 0, 0);                 // directed read, 0x96
    run_frame(1'b0, 7'h33, 8'h5A, 1, 4);                 // abort after 4 data bits
    run_frame(1'b1, 7'h11, 8'h00, 3, 3);                 // reset during read
    run_frame(1'b0, 7'h11, DW'($urandom), 0, 0);         // recovery frames
    run_frame(1'b1, 7'h11, 8'h00, 0, 0);
    run_frame(1'b0, AW'($urandom), DW'($urandom), 2, 0); // cs on final posedge

    for (int n = 0; n < 40; n++) begin
      run_frame(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
                ($urandom_range(0, 9) == 0) ? 1 : 0, $urandom_range(0, DW - 1));
    end

    step(5);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL leftover_txn: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spi_frame_controller.md
SPI_FRAME_CONTROLLER -- requirements
Module: spi_frame_controller

Interface
REQ-001 Parameter ADDR_WIDTH, default 7, SHALL set the register address width.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the register data width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 reset_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 cs_cond  input  1  SHALL carry the conditioned chip select, active low.
REQ-006 sclk_posedge  input  1  SHALL carry a one-clk pulse per conditioned SCLK rising edge.
REQ-007 sclk_negedge  input  1  SHALL carry a one-clk pulse per conditioned SCLK falling edge.
REQ-008 mosi_cond  input  1  SHALL carry the conditioned MOSI level.
REQ-009 rd_data  input  DATA_WIDTH  SHALL carry register-file read data, valid one clk after rd_en.
REQ-010 addr  output  ADDR_WIDTH  SHALL carry the captured register address.
REQ-011 wr_data  output  DATA_WIDTH  SHALL carry the captured write data.
REQ-012 wr_en  output  1  SHALL be the register-file write strobe.
REQ-013 rd_en  output  1  SHALL be the register-file read strobe.
REQ-014 miso  output  1  SHALL carry the serial read data.
REQ-015 miso_oe  output  1  SHALL be the MISO tristate enable.
REQ-016 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-017 States SHALL be: IDLE, ADDR, READ_REQ, READ_LOAD, READ_TX, WRITE_RX, WRITE_COMMIT, DONE.
REQ-018 IDLE -> ADDR SHALL occur on the first clk with cs_cond=0.
REQ-019 ADDR SHALL shift mosi_cond into an (ADDR_WIDTH+1)-bit register MSB first on each sclk_posedge: ADDR_WIDTH address bits, then the R/W bit (1=read).
REQ-020 Bit counting SHALL use one counter, cleared on entry to ADDR, READ_TX and WRITE_RX, and incremented only on sclk_posedge.
REQ-021 On the ADDR_WIDTH+1-th posedge: addr updates to the captured address; next state SHALL be READ_REQ if R/W=1, otherwise WRITE_RX.
REQ-022 READ_REQ SHALL last exactly one clk with rd_en=1, then go to READ_LOAD.
REQ-023 READ_LOAD SHALL last exactly one clk, load rd_data into the tx shift register, then go to READ_TX.
REQ-024 miso SHALL equal tx[MSB] while in READ_TX; miso_oe SHALL be 1 only in READ_TX.
REQ-025 The first sclk_negedge after the final address posedge SHALL be the present edge and SHALL NOT shift, even if it arrives during READ_REQ or READ_LOAD; a flag records that it occurred.
REQ-026 Each later sclk_negedge in READ_TX SHALL shift tx left by one, zero-filling the LSB.
REQ-027 READ_TX SHALL go to DONE after DATA_WIDTH sclk_posedge pulses.
REQ-028 WRITE_RX SHALL shift mosi_cond into wr_data MSB first on each sclk_posedge; after DATA_WIDTH bits it SHALL go to WRITE_COMMIT.
REQ-029 WRITE_COMMIT SHALL last one clk with wr_en=1, addr and wr_data stable, then go to DONE.
REQ-030 DONE SHALL ignore all SCLK pulses and SHALL go to IDLE when cs_cond=1.
REQ-031 cs_cond=1 in any state SHALL force IDLE on the next clk.
- If this occurs in WRITE_RX, wr_en SHALL never assert.
- cs deassertion SHALL take precedence over a simultaneous sclk pulse.
- If cs_cond=1 arrives during WRITE_COMMIT, the strobe already issued that cycle SHALL stand.
REQ-032 If sclk_posedge and sclk_negedge are high in the same clk, the posedge SHALL be processed and the negedge ignored.
REQ-033 rd_en and wr_en SHALL never both be 1, and neither SHALL be high for more than one consecutive clk.

Reset
REQ-034 reset_n=0 SHALL immediately force:
- state=IDLE;
- addr, wr_data, tx register, bit counter and present-edge flag to 0;
- wr_en, rd_en, miso, miso_oe and busy to 0.
REQ-035 Reset asserted mid-frame SHALL abort the frame without any wr_en or rd_en pulse.
REQ-036 After reset_n rises, the block SHALL wait for a fresh cs_cond=0 before entering ADDR.

Verification
REQ-037 Write frame, cs=0, bits 0x2A,R/W=0 then 0xC3 -> exactly one wr_en pulse with addr=0x2A, wr_data=0xC3; then DONE; IDLE after cs=1.
REQ-038 Read frame addr=0x05, R/W=1, rd_data=0x96 -> one rd_en pulse; miso sampled on the next 8 posedges = 1,0,0,1,0,1,1,0; miso_oe=1 only during READ_TX.
REQ-039 cs=1 after 4 write-data bits -> IDLE next clk, wr_en never asserted, busy=0.
REQ-040 reset_n=0 during READ_TX -> all outputs 0 asynchronously; next frame with addr=0x11 completes correctly.
REQ-041 Same-clk sclk_posedge+sclk_negedge during WRITE_RX -> one bit shifted, no other effect; cs=1 coincident with the final posedge -> no wr_en.
